// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Purpose : shared types and constants for the MM:SS stopwatch controller.
//   - state_t     : run-state FSM encoding (IDLE, RUN, PAUSE), 2 bits
//   - bcd_pair_t  : one BCD digit pair, tens in [7:4], units in [3:0]
//   - BCD_*_MAX   : last legal value of the units / tens digit of a mod-60 pair
// No ports (package).
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [7:0] bcd_pair_t;

  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;

  // Last value of a mod-60 digit pair (8'h59).
  localparam bcd_pair_t BCD_PAIR_MAX = {BCD_TENS_MAX, BCD_UNIT_MAX};

  // Next value of a mod-60 BCD digit pair; 59 rolls over to 00.
  function automatic bcd_pair_t bcd_mod60_inc(input bcd_pair_t cur);
    bcd_pair_t nxt;
    nxt = cur;
    if (cur[3:0] == BCD_UNIT_MAX) begin
      nxt[3:0] = 4'd0;
      if (cur[7:4] == BCD_TENS_MAX) begin
        nxt[7:4] = 4'd0;
      end else begin
        nxt[7:4] = cur[7:4] + 4'd1;
      end
    end else begin
      nxt[3:0] = cur[3:0] + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_60_bcd_mod60_cnt.sv
// -----------------------------------------------------------------------------
// bcd_mod60_cnt
// Purpose : one mod-60 BCD digit pair (00..59) with enable, synchronous clear
//           and a carry-out that fires on the 59 -> 00 step.
// Ports   :
//   clk   in   rising-edge clock
//   _rst  in   asynchronous active-low reset (q -> 8'h00)
//   en    in   advance by one on this edge
//   clr   in   synchronous zero; wins over en
//   q     out  registered BCD digit pair, tens [7:4], units [3:0]
//   co    out  en && q == 8'h59 (combinational, feeds the next pair's en)
// -----------------------------------------------------------------------------
module bcd_mod60_cnt
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       _rst,
  input  logic       en,
  input  logic       clr,
  output logic [7:0] q,
  output logic       co
);

  bcd_pair_t r_q;
  bcd_pair_t w_q_nxt;

  // Next-count selection: clear, increment, or hold.
  always_comb begin
    w_q_nxt = r_q;
    if (clr) begin
      w_q_nxt = 8'h00;
    end else if (en) begin
      w_q_nxt = bcd_mod60_inc(r_q);
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Digit-pair register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_q <= 8'h00;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign q  = r_q;
  assign co = en && (r_q == BCD_PAIR_MAX);

endmodule

// File: rtl/stopwatch_ctrl_60.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl_60
// Purpose : run/pause/clear controller for an MM:SS BCD stopwatch. Owns the
//           tick prescaler and the run-state FSM; two bcd_mod60_cnt instances
//           (seconds, minutes) advance only on the enables issued here.
// Build option : define STOPWATCH_LAP_EN to add the lap-freeze display
//                (snapshot registers); undefined, lap is ignored.
// Parameters :
//   TICK_DIV  clk cycles per seconds tick (>= 2)
// Ports :
//   clk         in   rising-edge clock
//   _rst        in   asynchronous active-low reset
//   start_stop  in   one-cycle pulse, toggles RUN / PAUSE (starts from IDLE)
//   clear       in   one-cycle pulse, back to IDLE at 00:00 (beats start_stop)
//   lap         in   one-cycle pulse, lap freeze toggle (STOPWATCH_LAP_EN only)
//   sec         out  seconds BCD, tens [7:4], units [3:0]
//   min         out  minutes BCD, same format
//   running     out  high while in RUN
//   tick        out  one-cycle pulse with every seconds increment
//   wrap        out  one-cycle pulse on 59:59 -> 00:00, coincident with tick
// -----------------------------------------------------------------------------
module stopwatch_ctrl_60
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  state_t          r_state;
  logic [PS_W-1:0] r_ps;
  logic            r_running;
  logic            r_tick;
  logic            r_wrap;

  logic      w_tick_en;
  logic      w_sec_co;
  logic      w_min_co;
  bcd_pair_t w_sec_q;
  bcd_pair_t w_min_q;

  // A seconds step happens on the edge where the prescaler rolls over in RUN;
  // a same-cycle clear suppresses it since the count is being zeroed anyway.
  assign w_tick_en = (r_state == RUN) && (r_ps == PS_MAX) && !clear;

  // Run-state FSM, prescaler and registered status pulses.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state   <= IDLE;
      r_ps      <= {PS_W{1'b0}};
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (clear) begin
        r_state   <= IDLE;
        r_ps      <= {PS_W{1'b0}};
        r_running <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_stop) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end else begin
              r_state   <= IDLE;
              r_running <= 1'b0;
            end
          end
          RUN: begin
            // The prescaler still advances on the pausing edge, so a tick due
            // on that edge is taken and partial progress is kept.
            if (r_ps == PS_MAX) begin
              r_ps <= {PS_W{1'b0}};
            end else begin
              r_ps <= r_ps + {{(PS_W-1){1'b0}}, 1'b1};
            end
            r_tick <= w_tick_en;
            r_wrap <= w_min_co;
            if (start_stop) begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end else begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end
          end
          PAUSE: begin
            if (start_stop) begin
              r_state   <= RUN;
              r_running <= 1'b1;
            end else begin
              r_state   <= PAUSE;
              r_running <= 1'b0;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_ps      <= {PS_W{1'b0}};
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

  bcd_mod60_cnt u_sec_cnt (
    .clk  (clk),
    ._rst (_rst),
    .en   (w_tick_en),
    .clr  (clear),
    .q    (w_sec_q),
    .co   (w_sec_co)
  );

  // Minutes advance in the same edge as the seconds 59 -> 00 step.
  bcd_mod60_cnt u_min_cnt (
    .clk  (clk),
    ._rst (_rst),
    .en   (w_sec_co),
    .clr  (clear),
    .q    (w_min_q),
    .co   (w_min_co)
  );

`ifdef STOPWATCH_LAP_EN
  logic      r_frozen;
  bcd_pair_t r_snap_sec;
  bcd_pair_t r_snap_min;

  // Lap freeze flag and display snapshot; the live count keeps running.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_frozen   <= 1'b0;
      r_snap_sec <= 8'h00;
      r_snap_min <= 8'h00;
    end else if (clear) begin
      r_frozen <= 1'b0;
    end else if (lap && ((r_state == RUN) || (r_state == PAUSE))) begin
      if (r_frozen) begin
        r_frozen <= 1'b0;
      end else begin
        r_frozen   <= 1'b1;
        r_snap_sec <= w_sec_q;
        r_snap_min <= w_min_q;
      end
    end else begin
      r_frozen <= r_frozen;
    end
  end

  // Register-to-output select only; no input reaches sec/min combinationally.
  assign sec = r_frozen ? r_snap_sec : w_sec_q;
  assign min = r_frozen ? r_snap_min : w_min_q;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign sec = w_sec_q;
  assign min = w_min_q;
`endif

  assign running = r_running;
  assign tick    = r_tick;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl_60.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl_60
// Directed self-checking bench for stopwatch_ctrl_60 with TICK_DIV = 10 and a
// 10 ns clock. Inputs change and outputs are sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl_60;

  logic       clk;
  logic       _rst;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [7:0] sec;
  logic [7:0] min;
  logic       running;
  logic       tick;
  logic       wrap;

  int n_pass;
  int n_total;
  int n_tick;
  int n_wrap;

  stopwatch_ctrl_60 #(.TICK_DIV(10)) dut (
    .clk        (clk),
    ._rst       (_rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .sec        (sec),
    .min        (min),
    .running    (running),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges, counting tick and wrap pulses seen after each.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_tick += int'(tick);
      n_wrap += int'(wrap);
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_tick = 0; n_wrap = 0;
    _rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

    // Reset held low for 20 ns.
    #12;
    chk("rst_running", running, 1'b0);
    chk("rst_sec", sec, 8'h00);
    #8 _rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_sec", sec, 8'h00);
    chk("post_rst_min", min, 8'h00);
    chk("post_rst_running", running, 1'b0);

    // Idle: no ticks for 200 ns.
    n_tick = 0;
    cyc(20);
    chk("idle_no_tick", n_tick, 0);
    chk("idle_sec", sec, 8'h00);

    // Start: running from the next edge, first tick 10 cycles after.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("start_running", running, 1'b1);
    n_tick = 0;
    cyc(9);
    chk("pre_first_tick", n_tick, 0);
    chk("pre_first_sec", sec, 8'h00);
    cyc(1);
    chk("first_tick", tick, 1'b1);
    chk("first_sec", sec, 8'h01);
    cyc(1);
    chk("tick_one_cycle", tick, 1'b0);
    cyc(589);
    chk("sixty_sec", sec, 8'h00);
    chk("sixty_min", min, 8'h01);
    chk("sixty_tick", tick, 1'b1);

    // Run on to 59:58 (3538 more ticks) without any wrap.
    n_tick = 0; n_wrap = 0;
    cyc(35380);
    chk("preload_ticks", n_tick, 3538);
    chk("preload_no_wrap", n_wrap, 0);
    chk("preload_sec", sec, 8'h58);
    chk("preload_min", min, 8'h59);
    cyc(10);
    chk("s5959_sec", sec, 8'h59);
    chk("s5959_min", min, 8'h59);
    chk("s5959_wrap", wrap, 1'b0);
    chk("s5959_tick", tick, 1'b1);
    cyc(10);
    chk("wrap_sec", sec, 8'h00);
    chk("wrap_min", min, 8'h00);
    chk("wrap_pulse", wrap, 1'b1);
    chk("wrap_tick", tick, 1'b1);
    cyc(1);
    chk("wrap_one_cycle", wrap, 1'b0);

    // Prescaler is 1 now; pause on the edge where it reads 4.
    cyc(3);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("pause_running", running, 1'b0);
    n_tick = 0;
    cyc(100);
    chk("pause_no_tick", n_tick, 0);
    chk("pause_sec", sec, 8'h00);
    chk("pause_min", min, 8'h00);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("resume_running", running, 1'b1);
    cyc(4);
    chk("resume_early_tick", n_tick, 0);
    cyc(1);
    chk("resume_tick_5", tick, 1'b1);
    chk("resume_sec", sec, 8'h01);

    // Run to 00:37, then clear together with start_stop.
    cyc(360);
    chk("pre_clear_sec", sec, 8'h37);
    clear = 1'b1; start_stop = 1'b1; cyc(1); clear = 1'b0; start_stop = 1'b0;
    chk("clear_running", running, 1'b0);
    chk("clear_sec", sec, 8'h00);
    chk("clear_min", min, 8'h00);
    chk("clear_tick", tick, 1'b0);
    n_tick = 0;
    cyc(20);
    chk("clear_idle_no_tick", n_tick, 0);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_in_idle", running, 1'b0);

    // Asynchronous reset in the middle of RUN.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    cyc(25);
    chk("midrun_sec", sec, 8'h02);
    #2 _rst = 1'b0;
    #1;
    chk("async_rst_sec", sec, 8'h00);
    chk("async_rst_running", running, 1'b0);
    #3 _rst = 1'b1;
    cyc(1);
    chk("after_rst_running", running, 1'b0);

    // Lap at 00:12, five more ticks, second lap.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    cyc(120);
    chk("lap_pre_sec", sec, 8'h12);
    lap = 1'b1; cyc(1); lap = 1'b0;
    n_tick = 0;
    cyc(49);
    chk("lap_ticks", n_tick, 5);
`ifdef STOPWATCH_LAP_EN
    chk("lap_frozen_sec", sec, 8'h12);
`else
    chk("lap_ignored_sec", sec, 8'h17);
`endif
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_release_sec", sec, 8'h17);
    chk("lap_release_min", min, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
